// File: rtl/simd_ctrl_unit_v2_pkg.sv
// Shared types and field positions for the SIMD matrix-multiply controller.
package simd_ctrl_pkg;

    typedef enum logic [2:0] {
        OpNop    = 3'd0,
        OpFetchB = 3'd1,
        OpFetchA = 3'd2,
        OpMatmul = 3'd3,
        OpStore  = 3'd4,
        OpClear  = 3'd5
    } opcode_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetchB,
        StFetchA,
        StMatmul,
        StStore,
        StClear
    } state_e;

    localparam int unsigned OPC_LSB  = 0;
    localparam int unsigned ADDR_LSB = 3;

endpackage

// File: rtl/simd_ctrl_unit_v2_if.sv
// Instruction valid/ready channel between the GPIO instruction source and the controller.
interface simd_ctrl_unit_v2_if #(
    parameter int unsigned IW = 32
);
    logic [IW-1:0] INSTR;
    logic          INSTR_VALID;
    logic          INSTR_READY;

    modport master (output INSTR, output INSTR_VALID, input INSTR_READY);
    modport slave  (input INSTR, input INSTR_VALID, output INSTR_READY);
endinterface

// File: rtl/simd_pe_onehot_dec.sv
// Row-address to per-PE one-hot decoder; address 0 selects the most significant PE.
module simd_pe_onehot_dec #(
    parameter int unsigned N = 16,
    localparam int unsigned LogN = $clog2(N)
) (
    input  logic [LogN-1:0] addr,
    output logic [N-1:0]    onehot
);
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            onehot[i] = (addr == LogN'(N - 1 - i));
        end
    end
endmodule

// File: rtl/simd_ctrl_unit_v2.sv
// SIMD matrix-multiply controller: decodes instructions and sequences the PE array.
// Optional MATMUL cycle counter enabled by defining SIMD_CTRL_PERF_CNT_EN.
module simd_ctrl_unit_v2
    import simd_ctrl_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IW    = 32,
    localparam int unsigned LogN = $clog2(N)
) (
    input  logic               CLK,
    input  logic               RSTN,
    simd_ctrl_unit_v2_if.slave ibus,
    input  logic               ONSWT,
    output logic               OFFSWT,
    output logic               DONE,
    output logic               BUSY,
    output logic               ERR_ILLEGAL,
    output logic               MATAB_MUX,
    output logic               DOUT_MUX,
    output logic [LogN-1:0]    SEQ_A,
    output logic [LogN-1:0]    SEQ_B,
    output logic [LogN-1:0]    SEQ_DATC,
    output logic [N-1:0]       MAC_CTRL,
    output logic [N-1:0]       RST_MUL,
    output logic [N-1:0]       INC_PC,
    output logic [N-1:0]       MAT_MUX,
`ifdef SIMD_CTRL_PERF_CNT_EN
    output logic [31:0]        PERF_MAC_CYCLES,
`endif
    output logic [N-1:0]       WRITE_MAT
);
    localparam int unsigned CntW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [LogN-1:0] addr_c_q, addr_c_d;
    logic            off_q, off_d, done_q, done_d, err_q, err_d;
    logic            matab_q, matab_d, dout_q, dout_d;
    logic [LogN-1:0] seq_a_q, seq_a_d, seq_b_q, seq_b_d;
    logic [N-1:0]    mac_q, mac_d, rst_q, rst_d, inc_q, inc_d, mmux_q, mmux_d, wm_q, wm_d;

    logic            accept, halt;
    logic [2:0]      opc;
    logic [LogN-1:0] addr;
    logic [N-1:0]    onehot;

    assign opc    = ibus.INSTR[OPC_LSB +: 3];
    assign addr   = ibus.INSTR[ADDR_LSB +: LogN];
    assign halt   = ibus.INSTR[ADDR_LSB + LogN];
    assign accept = ibus.INSTR_VALID && ibus.INSTR_READY;

    assign ibus.INSTR_READY = (state_q == StIdle) && ONSWT && !off_q;
    assign BUSY             = (state_q != StIdle);

    simd_pe_onehot_dec #(.N(N)) u_wm_dec (
        .addr   (addr),
        .onehot (onehot)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        addr_c_d = addr_c_q;
        off_d    = off_q | (accept & halt);
        err_d    = accept && (opc == 3'd6 || opc == 3'd7);
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (opc)
                        OpFetchB: state_d = StFetchB;
                        OpFetchA: state_d = StFetchA;
                        OpMatmul: state_d = StMatmul;
                        OpStore:  state_d = StStore;
                        OpClear:  state_d = StClear;
                        default:  state_d = StIdle;
                    endcase
                end
            end
            // Loop runs to completion regardless of ONSWT; only reset aborts it.
            StMatmul: begin
                if (cnt_q == CntLast) state_d = StIdle;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Controls are decoded from the next state so they register alongside it.
        done_d  = 1'b0;
        matab_d = 1'b1;
        dout_d  = 1'b0;
        seq_a_d = '0;
        seq_b_d = '0;
        mac_d   = '0;
        rst_d   = '0;
        inc_d   = '0;
        mmux_d  = '0;
        wm_d    = '0;
        unique case (state_d)
            StIdle:   rst_d = '1;
            StFetchB: begin
                matab_d = 1'b0;
                seq_b_d = addr;
                wm_d    = onehot;
                done_d  = 1'b1;
            end
            StFetchA: begin
                seq_a_d  = addr;
                mmux_d   = '1;
                wm_d     = '1;
                addr_c_d = addr;
                done_d   = 1'b1;
            end
            StMatmul: begin
                mac_d  = '1;
                inc_d  = '1;
                done_d = (cnt_d == CntLast);
            end
            StStore: begin
                dout_d = 1'b1;
                rst_d  = '1;
                done_d = 1'b1;
            end
            StClear: begin
                rst_d    = '1;
                addr_c_d = '0;
                done_d   = 1'b1;
            end
            default: rst_d = '1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_c_q <= '0;
            off_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            matab_q  <= 1'b1;
            dout_q   <= 1'b0;
            seq_a_q  <= '0;
            seq_b_q  <= '0;
            mac_q    <= '0;
            rst_q    <= '1;
            inc_q    <= '0;
            mmux_q   <= '0;
            wm_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_c_q <= addr_c_d;
            off_q    <= off_d;
            done_q   <= done_d;
            err_q    <= err_d;
            matab_q  <= matab_d;
            dout_q   <= dout_d;
            seq_a_q  <= seq_a_d;
            seq_b_q  <= seq_b_d;
            mac_q    <= mac_d;
            rst_q    <= rst_d;
            inc_q    <= inc_d;
            mmux_q   <= mmux_d;
            wm_q     <= wm_d;
        end
    end

    assign OFFSWT      = off_q;
    assign DONE        = done_q;
    assign ERR_ILLEGAL = err_q;
    assign MATAB_MUX   = matab_q;
    assign DOUT_MUX    = dout_q;
    assign SEQ_A       = seq_a_q;
    assign SEQ_B       = seq_b_q;
    assign SEQ_DATC    = addr_c_q;
    assign MAC_CTRL    = mac_q;
    assign RST_MUL     = rst_q;
    assign INC_PC      = inc_q;
    assign MAT_MUX     = mmux_q;
    assign WRITE_MAT   = wm_q;

`ifdef SIMD_CTRL_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge CLK) begin
        if (!RSTN || state_q == StClear) begin
            perf_q <= '0;
        end else if (state_q == StMatmul && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign PERF_MAC_CYCLES = perf_q;
`endif
endmodule

// File: tb/tb_simd_ctrl_unit_v2.sv
// Directed bench for simd_ctrl_unit_v2: a 16-PE/DEPTH-16 instance and a 4-PE/DEPTH-3 instance.
module tb_simd_ctrl_unit_v2;
    logic CLK = 1'b0;
    logic RSTN;
    logic ONSWT;
    always #5 CLK = ~CLK;

    simd_ctrl_unit_v2_if #(.IW(32)) bus0 ();
    simd_ctrl_unit_v2_if #(.IW(32)) bus1 ();

    logic        off0, done0, busy0, err0, matab0, dout0;
    logic [3:0]  sa0, sb0, sc0;
    logic [15:0] mac0, rst0, inc0, mmux0, wm0;
    logic        off1, done1, busy1, err1, matab1, dout1;
    logic [1:0]  sa1, sb1, sc1;
    logic [3:0]  mac1, rst1, inc1, mmux1, wm1;
`ifdef SIMD_CTRL_PERF_CNT_EN
    logic [31:0] perf0, perf1;
`endif

    simd_ctrl_unit_v2 #(.N(16), .DEPTH(16), .IW(32)) dut0 (
        .CLK(CLK), .RSTN(RSTN), .ibus(bus0.slave), .ONSWT(ONSWT), .OFFSWT(off0), .DONE(done0),
        .BUSY(busy0), .ERR_ILLEGAL(err0), .MATAB_MUX(matab0), .DOUT_MUX(dout0), .SEQ_A(sa0),
        .SEQ_B(sb0), .SEQ_DATC(sc0), .MAC_CTRL(mac0), .RST_MUL(rst0), .INC_PC(inc0),
        .MAT_MUX(mmux0),
`ifdef SIMD_CTRL_PERF_CNT_EN
        .PERF_MAC_CYCLES(perf0),
`endif
        .WRITE_MAT(wm0)
    );

    simd_ctrl_unit_v2 #(.N(4), .DEPTH(3), .IW(32)) dut1 (
        .CLK(CLK), .RSTN(RSTN), .ibus(bus1.slave), .ONSWT(ONSWT), .OFFSWT(off1), .DONE(done1),
        .BUSY(busy1), .ERR_ILLEGAL(err1), .MATAB_MUX(matab1), .DOUT_MUX(dout1), .SEQ_A(sa1),
        .SEQ_B(sb1), .SEQ_DATC(sc1), .MAC_CTRL(mac1), .RST_MUL(rst1), .INC_PC(inc1),
        .MAT_MUX(mmux1),
`ifdef SIMD_CTRL_PERF_CNT_EN
        .PERF_MAC_CYCLES(perf1),
`endif
        .WRITE_MAT(wm1)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for ready, then presents one instruction for a single accepting edge.
    task automatic issue(input bit d1, input logic [31:0] instr);
        int k = 0;
        @(negedge CLK);
        while (!(d1 ? bus1.INSTR_READY : bus0.INSTR_READY) && k < 50) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 50) chk("issue_ready_timeout", 32'd0, 32'd1);
        if (d1) begin
            bus1.INSTR = instr;
            bus1.INSTR_VALID = 1'b1;
        end else begin
            bus0.INSTR = instr;
            bus0.INSTR_VALID = 1'b1;
        end
        @(posedge CLK);
        #1;
        bus0.INSTR_VALID = 1'b0;
        bus1.INSTR_VALID = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1 RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        done, err, busy, matab, dout;
        logic [3:0]  sa, sb, sc;
        logic [15:0] wm, mmux, rst, mac;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n_mac, n_done, done_at, n_rdy;

        //            instr         dn er bs mb do sa    sb    sc    wm        mmux      rst       mac
        vecs[0] = '{32'h0000_0019, 1, 0, 1, 0, 0, 4'd0, 4'd3, 4'd0, 16'h1000, 16'h0000, 16'h0000, 16'h0};
        vecs[1] = '{32'h0000_002A, 1, 0, 1, 1, 0, 4'd5, 4'd0, 4'd5, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0};
        vecs[2] = '{32'h0000_0004, 1, 0, 1, 1, 1, 4'd0, 4'd0, 4'd5, 16'h0000, 16'h0000, 16'hFFFF, 16'h0};
        vecs[3] = '{32'h0000_0005, 1, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0};
        vecs[4] = '{32'h0000_0001, 1, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 16'h8000, 16'h0000, 16'h0000, 16'h0};
        vecs[5] = '{32'h0000_0079, 1, 0, 1, 0, 0, 4'd0, 4'd15, 4'd0, 16'h0001, 16'h0000, 16'h0000, 16'h0};
        vecs[6] = '{32'h0000_0007, 0, 1, 0, 1, 0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0};
        vecs[7] = '{32'hFFFF_0006, 0, 1, 0, 1, 0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0};
        vecs[8] = '{32'h0000_0000, 0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0};
        vecs[9] = '{32'hABC0_004A, 1, 0, 1, 1, 0, 4'd9, 4'd0, 4'd9, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0};

        RSTN = 1'b0;
        ONSWT = 1'b0;
        bus0.INSTR = '0;
        bus0.INSTR_VALID = 1'b0;
        bus1.INSTR = '0;
        bus1.INSTR_VALID = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_rst_mul", 32'(rst0), 32'hFFFF);
        chk("rst_matab", 32'(matab0), 32'd1);
        chk("rst_ready_onswt0", 32'(bus0.INSTR_READY), 32'd0);
        chk("rst_vectors_zero", 32'(mac0 | inc0 | mmux0 | wm0), 32'd0);
        chk("rst_scalars_zero", 32'({done0, err0, dout0, off0, busy0}), 32'd0);
        chk("rst_seq_zero", 32'({sa0, sb0, sc0}), 32'd0);
        chk("rst_n4_rst_mul", 32'(rst1), 32'hF);
        RSTN = 1'b1;
        ONSWT = 1'b1;
        @(negedge CLK);
        chk("rst_ready_onswt1", 32'(bus0.INSTR_READY), 32'd1);

        // Small build: MSB-first one-hot and a 3-cycle MAC loop
        issue(1'b1, 32'h01);
        @(negedge CLK);
        chk("n4_fetchb_wm", 32'(wm1), 32'h8);
        chk("n4_fetchb_done", 32'(done1), 32'd1);
        issue(1'b1, 32'h03);
        n_mac = 0; n_done = 0; done_at = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (mac1 == 4'hF && inc1 == 4'hF) n_mac++;
            if (done1) begin n_done++; done_at = c; end
        end
        chk("n4_mac_cycles", 32'(n_mac), 32'd3);
        chk("n4_done_count", 32'(n_done), 32'd1);
        chk("n4_done_cycle", 32'(done_at), 32'd3);
`ifdef SIMD_CTRL_PERF_CNT_EN
        chk("n4_perf_after_matmul", perf1, 32'd3);
        issue(1'b1, 32'h05);
        @(negedge CLK);
        @(negedge CLK);
        chk("n4_perf_after_clear", perf1, 32'd0);
`endif
        // Halt bit on a real instruction: it executes and then blocks accepts
        issue(1'b1, 32'h31);
        @(negedge CLK);
        chk("n4_halt_wm", 32'(wm1), 32'h2);
        chk("n4_halt_seq_b", 32'(sb1), 32'd2);
        chk("n4_halt_offswt", 32'(off1), 32'd1);
        @(negedge CLK);
        chk("n4_halt_ready", 32'(bus1.INSTR_READY), 32'd0);

        // Single-cycle instruction table on the 16-PE build
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, vecs[i].instr);
            @(negedge CLK);
            chk($sformatf("v%0d_done", i), 32'(done0), 32'(vecs[i].done));
            chk($sformatf("v%0d_err", i), 32'(err0), 32'(vecs[i].err));
            chk($sformatf("v%0d_busy", i), 32'(busy0), 32'(vecs[i].busy));
            chk($sformatf("v%0d_ready", i), 32'(bus0.INSTR_READY), 32'(!vecs[i].busy));
            chk($sformatf("v%0d_matab", i), 32'(matab0), 32'(vecs[i].matab));
            chk($sformatf("v%0d_dout", i), 32'(dout0), 32'(vecs[i].dout));
            chk($sformatf("v%0d_seq", i), 32'({sa0, sb0, sc0}),
                32'({vecs[i].sa, vecs[i].sb, vecs[i].sc}));
            chk($sformatf("v%0d_wm", i), 32'(wm0), 32'(vecs[i].wm));
            chk($sformatf("v%0d_mmux", i), 32'(mmux0), 32'(vecs[i].mmux));
            chk($sformatf("v%0d_rst", i), 32'(rst0), 32'(vecs[i].rst));
            chk($sformatf("v%0d_mac", i), 32'(mac0 | inc0), 32'(vecs[i].mac));
            chk($sformatf("v%0d_offswt", i), 32'(off0), 32'd0);
            @(negedge CLK);
            chk($sformatf("v%0d_ready_t2", i), 32'(bus0.INSTR_READY), 32'd1);
            chk($sformatf("v%0d_pulse_end", i), 32'({done0, err0}), 32'd0);
        end

        // MATMUL, ONSWT dropped mid-loop
        issue(1'b0, 32'h03);
        n_mac = 0; n_done = 0; done_at = 0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge CLK);
            if (c == 5) ONSWT = 1'b0;
            if (c == 3) chk("mm_ready_in_loop", 32'(bus0.INSTR_READY), 32'd0);
            if (mac0 == 16'hFFFF && inc0 == 16'hFFFF) n_mac++;
            if (done0) begin n_done++; done_at = c; end
        end
        chk("mm_mac_cycles", 32'(n_mac), 32'd16);
        chk("mm_done_count", 32'(n_done), 32'd1);
        chk("mm_done_cycle", 32'(done_at), 32'd16);
        chk("mm_idle_after", 32'(busy0), 32'd0);
        ONSWT = 1'b1;

        // MATMUL aborted by reset in cycle 8
        issue(1'b0, 32'h2A);
        issue(1'b0, 32'h03);
        for (int c = 1; c <= 8; c++) @(negedge CLK);
        RSTN = 1'b0;
        @(negedge CLK);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_mac", 32'(mac0), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        chk("abort_addr_c", 32'(sc0), 32'd0);
        chk("abort_rst_mul", 32'(rst0), 32'hFFFF);
        RSTN = 1'b1;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (done0) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);

        // NOP with halt, then VALID held against a blocked controller
        issue(1'b0, 32'h80);
        @(negedge CLK);
        chk("halt_offswt", 32'(off0), 32'd1);
        chk("halt_ready", 32'(bus0.INSTR_READY), 32'd0);
        chk("halt_nop_no_done", 32'({done0, busy0}), 32'd0);
        bus0.INSTR = 32'h19;
        bus0.INSTR_VALID = 1'b1;
        n_rdy = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (bus0.INSTR_READY || busy0 || done0) n_rdy++;
        end
        chk("halt_blocked_10cyc", 32'(n_rdy), 32'd0);
        bus0.INSTR_VALID = 1'b0;
        do_reset();
        @(negedge CLK);
        chk("halt_cleared_by_reset", 32'({off0, off1}), 32'd0);
        chk("ready_after_reset", 32'(bus0.INSTR_READY), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
